// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the STRV32I memory stage:
// funct3 codes, FSM states and exception causes.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the byte/halfword lane
// from the read word and sign- or zero-extends it.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [2:0]  funct3_in,
    input  logic [1:0]  lane_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_in[{lane_in, 3'b000} +: 8];
        half_sel = lane_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        data_out = '0;
        unique case (funct3_in)
            F3_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_out = {24'd0, byte_sel};
            F3_H:    data_out = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_out = {16'd0, half_sel};
            F3_W:    data_out = rdata_in;
            default: data_out = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/gnt/rvalid data-memory master
// with load alignment, store lane replication and fault reporting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          TIMEOUT_EN     = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_in,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_wmask_out,
    input  logic        mem_gnt_in,
    input  logic        mem_rvalid_in,
    input  logic [31:0] mem_rdata_in,
    output logic [31:0] lu_output_out,
    output logic        lsu_busy_out,
    output logic        lsu_done_out,
    output logic        lsu_exc_out,
    output logic [1:0]  lsu_exc_cause_out
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] lu_q, lu_d;
    logic        done_q, done_d, exc_q, exc_d;
    logic [1:0]  cause_q, cause_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;

    logic        op_valid, is_load, f3_legal, misalign, accept;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [31:0] lu_ext;

    assign op_valid = load_in | store_in;
    assign is_load  = load_in;

    always_comb begin
        f3_legal = 1'b0;
        unique case (funct3_in)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = is_load;
            default:          f3_legal = 1'b0;
        endcase
        misalign = ((funct3_in[1:0] == 2'b01) && addr_in[0])
                || ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
    end

    assign accept = (state_q == S_IDLE) && op_valid && f3_legal && !misalign;

    always_comb begin
        st_wdata = rs2_in;
        st_wmask = 4'b1111;
        unique case (funct3_in[1:0])
            2'b00: begin
                st_wdata = {4{rs2_in[7:0]}};
                st_wmask = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_in[15:0]}};
                st_wmask = 4'b0011 << addr_in[1:0];
            end
            default: begin
                st_wdata = rs2_in;
                st_wmask = 4'b1111;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata_in  (mem_rdata_in),
        .funct3_in (f3_q),
        .lane_in   (lane_q),
        .data_out  (lu_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        lu_d    = lu_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        cause_d = CAUSE_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid && !f3_legal) begin
                    exc_d   = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (op_valid && misalign) begin
                    exc_d   = 1'b1;
                    cause_d = CAUSE_MISALIGN;
                end else if (accept) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = !is_load;
                    addr_d  = {addr_in[31:2], 2'b00};
                    wdata_d = is_load ? 32'd0 : st_wdata;
                    wmask_d = is_load ? 4'd0 : st_wmask;
                    f3_d    = funct3_in;
                    lane_d  = addr_in[1:0];
                end
            end
            S_REQ: begin
                if (mem_gnt_in) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                // rvalid wins over a timeout reached in the same cycle
                if (mem_rvalid_in) begin
                    lu_d    = lu_ext;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (TIMEOUT_EN && (cnt_q == TO_LAST)) begin
                    state_d = S_IDLE;
                    exc_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            lu_q    <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            lu_q    <= lu_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    assign mem_req_out       = req_q;
    assign mem_we_out        = we_q;
    assign mem_addr_out      = addr_q;
    assign mem_wdata_out     = wdata_q;
    assign mem_wmask_out     = wmask_q;
    assign lu_output_out     = lu_q;
    assign lsu_done_out      = done_q;
    assign lsu_exc_out       = exc_q;
    assign lsu_exc_cause_out = cause_q;
    assign lsu_busy_out      = (state_q == S_REQ) || (state_q == S_WAIT) || accept;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus
// timeout, rvalid-at-limit and mid-transaction reset sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0, store_i = 1'b0;
    logic [2:0]  f3_i = '0;
    logic [31:0] addr_i = '0, rs2_i = '0;
    logic        gnt_i = 1'b0, rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        req_o, we_o, busy_o, done_o, exc_o;
    logic [31:0] maddr_o, wdata_o, lu_o;
    logic [3:0]  wmask_o;
    logic [1:0]  cause_o;

    logic [31:0] ref_rdata = '0;
    logic [2:0]  ref_f3 = '0;
    logic [1:0]  ref_lane = '0;
    logic [31:0] ref_out;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] lu_prev = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16), .TIMEOUT_EN(1'b1)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .load_in           (load_i),
        .store_in          (store_i),
        .funct3_in         (f3_i),
        .addr_in           (addr_i),
        .rs2_in            (rs2_i),
        .mem_req_out       (req_o),
        .mem_we_out        (we_o),
        .mem_addr_out      (maddr_o),
        .mem_wdata_out     (wdata_o),
        .mem_wmask_out     (wmask_o),
        .mem_gnt_in        (gnt_i),
        .mem_rvalid_in     (rvalid_i),
        .mem_rdata_in      (rdata_i),
        .lu_output_out     (lu_o),
        .lsu_busy_out      (busy_o),
        .lsu_done_out      (done_o),
        .lsu_exc_out       (exc_o),
        .lsu_exc_cause_out (cause_o)
    );

    lsu_load_align u_ref (
        .rdata_in  (ref_rdata),
        .funct3_in (ref_f3),
        .lane_in   (ref_lane),
        .data_out  (ref_out)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        logic [31:0] e_lu;
        logic [31:0] e_wd;
        logic [3:0]  e_wm;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        load_i  = ld;
        store_i = st;
        f3_i    = f3;
        addr_i  = a;
        rs2_i   = d;
    endtask

    task automatic run_op(input vec_t t);
        step();
        present(t.ld, t.st, t.f3, t.addr, t.rs2);
        #2;
        chkb("busy_accept", busy_o, 1'b1);
        step();
        present(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        chkb("req_up", req_o, 1'b1);
        chk("mem_addr", maddr_o, {t.addr[31:2], 2'b00});
        chkb("we", we_o, !t.ld);
        chk("wmask", 32'(wmask_o), t.ld ? 32'd0 : 32'(t.e_wm));
        if (!t.ld) chk("wdata", wdata_o, t.e_wd);
        repeat (t.gd) begin
            step();
            chkb("req_hold", req_o, 1'b1);
            chkb("busy_req", busy_o, 1'b1);
            chk("wmask_hold", 32'(wmask_o), t.ld ? 32'd0 : 32'(t.e_wm));
            if (!t.ld) chk("wdata_hold", wdata_o, t.e_wd);
        end
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        if (t.ld) begin
            chkb("req_drop", req_o, 1'b0);
            repeat (t.rd) begin
                chkb("busy_wait", busy_o, 1'b1);
                chkb("done_early", done_o, 1'b0);
                step();
            end
            rvalid_i = 1'b1;
            rdata_i  = t.rdata;
            step();
            rvalid_i = 1'b0;
            rdata_i  = '0;
            lu_prev  = t.e_lu;
        end
        chkb("done_pulse", done_o, 1'b1);
        chkb("busy_done", busy_o, 1'b0);
        chk("lu_output", lu_o, lu_prev);
        step();
        chkb("done_end", done_o, 1'b0);
        chkb("busy_after", busy_o, 1'b0);
    endtask

    task automatic run_fault(input vec_t t);
        step();
        present(t.ld, t.st, t.f3, t.addr, t.rs2);
        #2;
        chkb("busy_fault", busy_o, 1'b0);
        step();
        present(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        chkb("exc_pulse", exc_o, 1'b1);
        chk("exc_cause", 32'(cause_o), 32'(t.e_cause));
        chkb("req_fault", req_o, 1'b0);
        step();
        chkb("exc_end", exc_o, 1'b0);
        chkb("req_fault2", req_o, 1'b0);
        chkb("busy_fault2", busy_o, 1'b0);
    endtask

    task automatic load_to_wait(input logic [31:0] a);
        step();
        present(1'b1, 1'b0, F3_W, a, 32'd0);
        step();
        present(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 1'b0, F3_B,  32'h1003, 32'h0,        32'h80FF1234, 1, 1, 32'hFFFFFF80, 32'h0,        4'h0, 2'b00};
        v[1]  = '{1'b1, 1'b0, F3_HU, 32'h2002, 32'h0,        32'hBEEF0000, 0, 0, 32'h0000BEEF, 32'h0,        4'h0, 2'b00};
        v[2]  = '{1'b1, 1'b0, F3_H,  32'h2002, 32'h0,        32'hBEEF0000, 0, 2, 32'hFFFFBEEF, 32'h0,        4'h0, 2'b00};
        v[3]  = '{1'b0, 1'b1, F3_B,  32'h0010, 32'h123456AB, 32'h0,        3, 0, 32'h0,        32'hABABABAB, 4'h1, 2'b00};
        v[4]  = '{1'b0, 1'b1, F3_W,  32'h0020, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF, 4'hF, 2'b00};
        v[5]  = '{1'b0, 1'b1, F3_H,  32'h0022, 32'h0000CAFE, 32'h0,        1, 0, 32'h0,        32'hCAFECAFE, 4'hC, 2'b00};
        v[6]  = '{1'b1, 1'b0, F3_BU, 32'h0005, 32'h0,        32'h1122F344, 2, 1, 32'h000000F3, 32'h0,        4'h0, 2'b00};
        v[7]  = '{1'b1, 1'b0, F3_W,  32'h0008, 32'h0,        32'hCAFEBABE, 0, 0, 32'hCAFEBABE, 32'h0,        4'h0, 2'b00};
        v[8]  = '{1'b1, 1'b0, F3_W,  32'h0006, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 2'b01};
        v[9]  = '{1'b0, 1'b1, F3_H,  32'h0001, 32'h5555,     32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 2'b01};
        v[10] = '{1'b1, 1'b0, 3'b011, 32'h0000, 32'h0,       32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 2'b10};
        v[11] = '{1'b0, 1'b1, F3_BU, 32'h0000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 2'b10};
        v[12] = '{1'b0, 1'b1, F3_B,  32'h0013, 32'h000000A5, 32'h0,        0, 0, 32'h0,        32'hA5A5A5A5, 4'h8, 2'b00};
        v[13] = '{1'b1, 1'b1, F3_W,  32'h0030, 32'hFFFFFFFF, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 32'h0,        4'h0, 2'b00};

        repeat (3) step();
        chkb("rst_req", req_o, 1'b0);
        chkb("rst_we", we_o, 1'b0);
        chk("rst_addr", maddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wmask", 32'(wmask_o), 32'd0);
        chk("rst_lu", lu_o, 32'd0);
        chkb("rst_done", done_o, 1'b0);
        chkb("rst_exc", exc_o, 1'b0);
        chk("rst_cause", 32'(cause_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (v[i].e_cause != 2'b00) begin
                run_fault(v[i]);
            end else begin
                if (v[i].ld) begin
                    ref_rdata = v[i].rdata;
                    ref_f3    = v[i].f3;
                    ref_lane  = v[i].addr[1:0];
                    #1;
                    chk("ref_align", ref_out, v[i].e_lu);
                end
                run_op(v[i]);
            end
        end

        // rvalid withheld: timeout after 16 WAIT cycles
        load_to_wait(32'h40);
        for (int i = 0; i < 16; i++) begin
            chkb("to_busy", busy_o, 1'b1);
            chkb("to_exc_early", exc_o, 1'b0);
            step();
        end
        chkb("to_exc", exc_o, 1'b1);
        chk("to_cause", 32'(cause_o), 32'(CAUSE_TIMEOUT));
        chkb("to_busy_end", busy_o, 1'b0);
        chkb("to_done", done_o, 1'b0);
        chk("to_lu_kept", lu_o, lu_prev);

        // rvalid on the final WAIT cycle still succeeds
        load_to_wait(32'h44);
        for (int i = 0; i < 15; i++) step();
        rvalid_i = 1'b1;
        rdata_i  = 32'h13572468;
        step();
        rvalid_i = 1'b0;
        chkb("lim_done", done_o, 1'b1);
        chkb("lim_exc", exc_o, 1'b0);
        chk("lim_lu", lu_o, 32'h13572468);
        step();

        // reset while waiting for rvalid
        load_to_wait(32'h50);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chkb("mr_req", req_o, 1'b0);
        chk("mr_lu", lu_o, 32'd0);
        chkb("mr_busy", busy_o, 1'b0);
        rvalid_i = 1'b1;
        rdata_i  = 32'hFFFF0000;
        step();
        rvalid_i = 1'b0;
        chkb("mr_stale_done", done_o, 1'b0);
        chk("mr_stale_lu", lu_o, 32'd0);
        step();
        chkb("mr_idle_done", done_o, 1'b0);
        chkb("mr_idle_req", req_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
